// File: rtl/ro_puf_pkg.sv
// rtl/ro_puf_pkg.sv - shared state encoding and default sizing for the RO pair compare engine
package ro_puf_pkg;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_N_PAIRS = 8;
    localparam int DEF_WINDOW  = 21;
    localparam int DEF_VOTES   = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RUN     = 3'd2,
        ST_COMPARE = 3'd3,
        ST_RESOLVE = 3'd4
    } state_t;

endpackage

// File: rtl/ro_pair_compare_engine_if.sv
// rtl/ro_pair_compare_engine_if.sv - request, RO count and response bundle of the compare engine
interface ro_pair_compare_engine_if
    import ro_puf_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int N_PAIRS = DEF_N_PAIRS
);
    logic                       start;
    logic [N_PAIRS*CNT_W-1:0]   up_cnt;
    logic [N_PAIRS*CNT_W-1:0]   down_cnt;
    logic                       cnt_clr;
    logic                       cnt_en;
    logic                       busy;
    logic                       done;
    logic [N_PAIRS-1:0]         response;
    logic [N_PAIRS-1:0]         unstable;

    modport master (
        output start, up_cnt, down_cnt,
        input  cnt_clr, cnt_en, busy, done, response, unstable
    );

    modport slave (
        input  start, up_cnt, down_cnt,
        output cnt_clr, cnt_en, busy, done, response, unstable
    );
endinterface

// File: rtl/puf_vote_acc.sv
// rtl/puf_vote_acc.sv - per-pair saturating vote counter with majority and unanimity decode
module puf_vote_acc #(
    parameter int VOTES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic majority,
    output logic unstable
);
    localparam int VOTE_W = $clog2(VOTES + 1);

    logic [VOTE_W-1:0] votes;

    // Count rounds in which the pair bit was 1; saturate so a stray extra round cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            votes <= '0;
        end else if (clr) begin
            votes <= '0;
        end else if (inc && (votes != VOTE_W'(VOTES))) begin
            votes <= votes + 1'b1;
        end
    end

    assign majority = (votes > VOTE_W'(VOTES / 2));
    assign unstable = (votes != '0) && (votes != VOTE_W'(VOTES));
endmodule

// File: rtl/ro_pair_compare_engine.sv
// rtl/ro_pair_compare_engine.sv - RO PUF engine: count window, serial pair compare, majority vote
module ro_pair_compare_engine
    import ro_puf_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int N_PAIRS = DEF_N_PAIRS,
    parameter int WINDOW  = DEF_WINDOW,
    parameter int VOTES   = DEF_VOTES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ro_pair_compare_engine_if.slave   bus
);
    localparam int IDX_W = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
    localparam int WIN_W = 8;
    localparam int RND_W = $clog2(VOTES + 1);

    state_t             state;
    logic [WIN_W-1:0]   win_cnt;
    logic [IDX_W-1:0]   pair_idx;
    logic [RND_W-1:0]   round;
    logic               cnt_clr_q;
    logic               cnt_en_q;
    logic               busy_q;
    logic               done_q;
    logic [N_PAIRS-1:0] response_q;
    logic [N_PAIRS-1:0] unstable_q;

    logic [CNT_W-1:0]   up_arr [N_PAIRS];
    logic [CNT_W-1:0]   dn_arr [N_PAIRS];
    logic [CNT_W-1:0]   sel_up;
    logic [CNT_W-1:0]   sel_dn;
    logic               pair_bit;
    logic               acc_clr;
    logic [N_PAIRS-1:0] maj_vec;
    logic [N_PAIRS-1:0] unst_vec;

    // One shared comparator: the current pair is picked out of the packed count buses by index.
    for (genvar g = 0; g < N_PAIRS; g++) begin : g_unpack
        assign up_arr[g] = bus.up_cnt[g*CNT_W +: CNT_W];
        assign dn_arr[g] = bus.down_cnt[g*CNT_W +: CNT_W];
    end

    assign sel_up   = up_arr[pair_idx];
    assign sel_dn   = dn_arr[pair_idx];
    assign pair_bit = (sel_up >= sel_dn);
    assign acc_clr  = (state == ST_RESOLVE);

    for (genvar i = 0; i < N_PAIRS; i++) begin : g_pair
        puf_vote_acc #(
            .VOTES (VOTES)
        ) u_acc (
            .clk      (clk),
            .rst_n    (rst_n),
            .inc      ((state == ST_COMPARE) && (pair_idx == IDX_W'(i)) && pair_bit),
            .clr      (acc_clr),
            .majority (maj_vec[i]),
            .unstable (unst_vec[i])
        );
    end

    // Sequencer: clear -> count window -> compare each pair, repeated per vote round, then resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            win_cnt    <= '0;
            pair_idx   <= '0;
            round      <= '0;
            cnt_clr_q  <= 1'b0;
            cnt_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            response_q <= '0;
            unstable_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state     <= ST_CLEAR;
                        cnt_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state     <= ST_RUN;
                    cnt_clr_q <= 1'b0;
                    cnt_en_q  <= 1'b1;
                    win_cnt   <= '0;
                end
                ST_RUN: begin
                    if (win_cnt == WIN_W'(WINDOW - 1)) begin
                        state    <= ST_COMPARE;
                        cnt_en_q <= 1'b0;
                        win_cnt  <= '0;
                        pair_idx <= '0;
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                ST_COMPARE: begin
                    if (pair_idx == IDX_W'(N_PAIRS - 1)) begin
                        pair_idx <= '0;
                        if (round < RND_W'(VOTES - 1)) begin
                            round     <= round + 1'b1;
                            state     <= ST_CLEAR;
                            cnt_clr_q <= 1'b1;
                        end else begin
                            state <= ST_RESOLVE;
                        end
                    end else begin
                        pair_idx <= pair_idx + 1'b1;
                    end
                end
                ST_RESOLVE: begin
                    response_q <= maj_vec;
                    unstable_q <= unst_vec;
                    round      <= '0;
                    state      <= ST_IDLE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt_clr_q <= 1'b0;
                    cnt_en_q  <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cnt_clr  = cnt_clr_q;
    assign bus.cnt_en   = cnt_en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.response = response_q;
    assign bus.unstable = unstable_q;
endmodule

// File: tb/tb_ro_pair_compare_engine.sv
// tb/tb_ro_pair_compare_engine.sv - directed self-checking bench for ro_pair_compare_engine
module tb_ro_pair_compare_engine;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ro_pair_compare_engine_if #(.CNT_W(16), .N_PAIRS(8)) bus_a ();
    ro_pair_compare_engine_if #(.CNT_W(16), .N_PAIRS(4)) bus_b ();

    ro_pair_compare_engine #(
        .CNT_W(16), .N_PAIRS(8), .WINDOW(21), .VOTES(3)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    ro_pair_compare_engine #(
        .CNT_W(16), .N_PAIRS(4), .WINDOW(2), .VOTES(1)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [15:0] up_tab [3][8];
    logic [15:0] dn_tab [3][8];
    bit          swap = 1'b0;
    int          round_a = 0;
    int          done_a = 0;
    int          en_a = 0;
    int          ovl_a = 0;

    // External RO counter stand-in: each clear loads that round's counts (optionally swapped).
    always @(negedge clk) begin
        if (bus_a.cnt_clr) begin
            for (int i = 0; i < 8; i++) begin
                bus_a.up_cnt[i*16 +: 16]   = swap ? dn_tab[round_a][i] : up_tab[round_a][i];
                bus_a.down_cnt[i*16 +: 16] = swap ? up_tab[round_a][i] : dn_tab[round_a][i];
            end
            round_a = (round_a == 2) ? 0 : round_a + 1;
        end else if (!bus_a.busy) begin
            round_a = 0;
        end
    end

    // Running tallies of done pulses, enable cycles and clear/enable overlap.
    always @(negedge clk) begin
        if (bus_a.done) done_a++;
        if (bus_a.cnt_en) en_a++;
        if (bus_a.cnt_en && bus_a.cnt_clr) ovl_a++;
        if (bus_b.cnt_en && bus_b.cnt_clr) ovl_a++;
    end

    task automatic wait_done(input bit poke, input bit chain, output int lat, output logic [7:0] mid_resp);
        int cyc;
        bit seen;
        cyc = 0;
        seen = 1'b0;
        mid_resp = '0;
        @(posedge clk);
        @(negedge clk);
        bus_a.start = 1'b0;
        while (!seen && cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            bus_a.start = poke && (cyc == 10 || cyc == 25);
            if (cyc == 50) mid_resp = bus_a.response;
            if (bus_a.done) begin
                seen = 1'b1;
                if (chain) bus_a.start = 1'b1;
            end
        end
        lat = seen ? cyc : -1;
    endtask

    task automatic run_b(output int lat, output int en);
        int cyc;
        bit seen;
        cyc = 0;
        seen = 1'b0;
        en = 0;
        @(negedge clk);
        bus_b.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_b.start = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus_b.cnt_en) en++;
            if (bus_b.done) seen = 1'b1;
        end
        lat = seen ? cyc : -1;
    endtask

    initial begin
        int lat;
        int en;
        int snap;
        logic [7:0] mid;

        for (int r = 0; r < 3; r++) begin
            up_tab[r][0] = 16'h1200; dn_tab[r][0] = 16'h1100;
            up_tab[r][1] = 16'h0100; dn_tab[r][1] = 16'h0200;
            up_tab[r][2] = (r == 2) ? 16'h0500 : 16'h0300; dn_tab[r][2] = 16'h0400;
            up_tab[r][3] = 16'h0800; dn_tab[r][3] = 16'h0800;
            up_tab[r][4] = 16'hFFFF; dn_tab[r][4] = 16'h0000;
            up_tab[r][5] = (r == 1) ? 16'h1FFF : 16'h2001; dn_tab[r][5] = 16'h2000;
            up_tab[r][6] = 16'h0000; dn_tab[r][6] = 16'hFFFF;
            up_tab[r][7] = 16'h8000; dn_tab[r][7] = 16'h7FFF;
        end

        rst_n = 1'b0;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        bus_b.up_cnt = '0;
        bus_b.down_cnt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_a", 32'({bus_a.cnt_clr, bus_a.cnt_en, bus_a.busy, bus_a.done, bus_a.response, bus_a.unstable}), 32'h0);
        chk("reset_b", 32'({bus_b.cnt_clr, bus_b.cnt_en, bus_b.busy, bus_b.done, bus_b.response, bus_b.unstable}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Run 1: plain request, default table.
        snap = en_a;
        bus_a.start = 1'b1;
        wait_done(1'b0, 1'b0, lat, mid);
        chk("run1_latency", 32'(lat), 32'd91);
        chk("run1_response", 32'(bus_a.response), 32'h0000_00B9);
        chk("run1_unstable", 32'(bus_a.unstable), 32'h0000_0024);
        chk("run1_en_cycles", 32'(en_a - snap), 32'd63);
        @(negedge clk);
        chk("done_one_cycle", 32'(bus_a.done), 32'h0);

        // Run 2: swapped table, start poked during RUN and COMPARE, chained into run 3.
        swap = 1'b1;
        snap = en_a;
        bus_a.start = 1'b1;
        wait_done(1'b1, 1'b1, lat, mid);
        chk("run2_latency_poked", 32'(lat), 32'd91);
        chk("run2_response", 32'(bus_a.response), 32'h0000_004E);
        chk("run2_unstable", 32'(bus_a.unstable), 32'h0000_0024);
        chk("run2_en_cycles", 32'(en_a - snap), 32'd63);
        swap = 1'b0;
        wait_done(1'b0, 1'b0, lat, mid);
        chk("run3_b2b_latency", 32'(lat), 32'd91);
        chk("run3_hold_mid", 32'(mid), 32'h0000_004E);
        chk("run3_response", 32'(bus_a.response), 32'h0000_00B9);
        repeat (100) @(negedge clk);
        chk("done_count", 32'(done_a), 32'd3);
        chk("busy_idle", 32'(bus_a.busy), 32'h0);

        // Reset at cycle 40 of a run.
        snap = done_a;
        bus_a.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrun_reset_outputs", 32'({bus_a.cnt_clr, bus_a.cnt_en, bus_a.busy, bus_a.done, bus_a.response, bus_a.unstable}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (120) @(negedge clk);
        chk("midrun_reset_no_done", 32'(done_a - snap), 32'h0);
        bus_a.start = 1'b1;
        wait_done(1'b0, 1'b0, lat, mid);
        chk("post_reset_latency", 32'(lat), 32'd91);
        chk("post_reset_response", 32'(bus_a.response), 32'h0000_00B9);
        chk("post_reset_unstable", 32'(bus_a.unstable), 32'h0000_0024);

        // Small configuration: 4 pairs, 1 vote, 2-cycle window.
        bus_b.up_cnt   = {16'd7, 16'd7, 16'd1, 16'd5};
        bus_b.down_cnt = {16'd8, 16'd7, 16'd2, 16'd3};
        run_b(lat, en);
        chk("small_latency", 32'(lat), 32'd8);
        chk("small_en_cycles", 32'(en), 32'd2);
        chk("small_response1", 32'(bus_b.response), 32'h5);
        chk("small_unstable1", 32'(bus_b.unstable), 32'h0);
        bus_b.up_cnt   = {16'hFFFF, 16'h0000, 16'h0009, 16'h0000};
        bus_b.down_cnt = {16'hFFFE, 16'h0000, 16'h0009, 16'h0001};
        run_b(lat, en);
        chk("small_latency2", 32'(lat), 32'd8);
        chk("small_response2", 32'(bus_b.response), 32'hE);
        @(negedge clk);
        chk("clr_en_overlap", 32'(ovl_a), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ro_pair_compare_engine.md
RO_PAIR_COMPARE_ENGINE -- requirements
Module: ro_pair_compare_engine

Interface
REQ-001 Parameter CNT_W, default 16: width of each RO counter value.
REQ-002 Parameter N_PAIRS, default 8: number of RO pairs compared; response width.
REQ-003 Parameter WINDOW, default 21: count cycles per evaluation round, 2..255.
REQ-004 Parameter VOTES, default 3: odd evaluation rounds per response, 1..15.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  request one response generation; sampled only in IDLE.
REQ-008 up_cnt  in  N_PAIRS*CNT_W  upper RO counts; pair i at bits [i*CNT_W +: CNT_W].
REQ-009 down_cnt  in  N_PAIRS*CNT_W  lower RO counts; same packing.
REQ-010 cnt_clr  out  1  clears external RO counters.
REQ-011 cnt_en  out  1  enables external RO counters.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse; response/unstable valid.
REQ-014 response  out  N_PAIRS  majority-voted PUF bits.
REQ-015 unstable  out  N_PAIRS  per-pair flag: votes not unanimous.

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, RUN, COMPARE, RESOLVE.
REQ-017 IDLE->CLEAR when start=1; start in any other state SHALL be ignored.
REQ-018 CLEAR lasts 1 cycle with cnt_clr=1, cnt_en=0; then RUN.
REQ-019 RUN holds cnt_en=1 for exactly WINDOW cycles (window counter 0..WINDOW-1); then COMPARE.
REQ-020 COMPARE lasts N_PAIRS cycles, cnt_en=0, counters frozen; cycle k evaluates pair k only.
REQ-021 Pair bit SHALL be 1 when up >= down (unsigned, full CNT_W), else 0; equality yields 1.
REQ-022 Per-pair vote counter, width clog2(VOTES+1), SHALL increment on bit=1; never wraps.
REQ-023 After pair N_PAIRS-1: round count < VOTES-1 -> CLEAR (round+1); else RESOLVE.
REQ-024 RESOLVE (1 cycle): response[i] = votes[i] > VOTES/2; unstable[i] = votes[i] != 0 and != VOTES; vote counters and round cleared; done=1 in the following cycle with state IDLE.
REQ-025 Latency start-sample to done high SHALL be VOTES*(1+WINDOW+N_PAIRS)+1 cycles (91 at defaults).
REQ-026 response/unstable SHALL hold between done pulses; updated only in RESOLVE.
REQ-027 start asserted in the same cycle done is high SHALL be accepted (back-to-back).
REQ-028 cnt_clr and cnt_en SHALL never be high together.

Reset
REQ-029 rst_n=0 SHALL force IDLE immediately, regardless of state.
REQ-030 Reset values: cnt_clr=0, cnt_en=0, busy=0, done=0, response=0, unstable=0, all counters 0.
REQ-031 Reset mid-operation SHALL discard partial votes; no done pulse follows.

Structure
REQ-032 Shared package ro_puf_pkg SHALL hold state enum and default CNT_W/WINDOW/VOTES constants.
REQ-033 One sub-module puf_vote_acc (per-pair vote counter plus majority/unstable decode), instantiated N_PAIRS times.
REQ-034 Pair selection in COMPARE SHALL use an index mux, not N_PAIRS parallel comparators.

Verification
REQ-035 Defaults, pair 0 up=0x1200/down=0x1100 every round -> response[0]=1, unstable[0]=0, done at cycle 91.
REQ-036 Pair 3 up=down=0x0800 -> response[3]=1 (tie rule), unstable[3]=0.
REQ-037 Pair 5 up>down in rounds 0,2, up<down in round 1 -> response[5]=1, unstable[5]=1.
REQ-038 start pulsed during RUN and COMPARE -> ignored; exactly one done, latency unchanged.
REQ-039 rst_n low at cycle 40 of a run -> all outputs 0 next cycle; no done; fresh start completes normally.
REQ-040 N_PAIRS=4, VOTES=1, WINDOW=2 -> done 8 cycles after start; cnt_en high exactly 2 cycles.
